// File: rtl/bus_arbiter_split.sv
// -----------------------------------------------------------------------------
// bus_arbiter_split
//
// Round-robin arbiter for a shared system bus, with support for split
// transactions. When the addressed slave splits, the owning master is parked
// and the bus is freed. The parked master is re-granted with priority once that
// slave pulses its split_done line.
//
// Ports:
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   mbreq        per-master bus request, held for the whole transaction
//   mbgrant      per-master grant (registered, one-hot or zero)
//   msplit       per-master "parked by split" flag
//   split_req    owner's addressed slave requests a split (1-cycle pulse)
//   split_slave  one-hot identity of the splitting slave, valid with split_req
//   split_done   per-slave "ready to complete parked transaction" pulse
//   bus_busy     a grant is active
//   owner_id     index of the current owner, 0 when idle
// -----------------------------------------------------------------------------
module bus_arbiter_split #(
    parameter int MASTER_COUNT = 2,
    parameter int SLAVE_COUNT  = 3,
    parameter int SIDX_WIDTH   = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [MASTER_COUNT-1:0] mbreq,
    output logic [MASTER_COUNT-1:0] mbgrant,
    output logic [MASTER_COUNT-1:0] msplit,
    input  logic                    split_req,
    input  logic [SLAVE_COUNT-1:0]  split_slave,
    input  logic [SLAVE_COUNT-1:0]  split_done,
    output logic                    bus_busy,
    output logic [2:0]              owner_id
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e                  state_q;
    logic [MASTER_COUNT-1:0] grant_q;
    logic [MASTER_COUNT-1:0] park_q;
    logic [MASTER_COUNT-1:0] resume_q;
    logic [SIDX_WIDTH-1:0]   slot_q [MASTER_COUNT];
    logic [2:0]              ptr_q;

    // One-hot to binary index; zero input gives index 0.
    function automatic logic [2:0] oh_to_idx(input logic [MASTER_COUNT-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int j = 0; j < MASTER_COUNT; j++) begin
            if (oh[j]) idx = idx | 3'(j);
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration helpers
    // ------------------------------------------------------------------
    logic [MASTER_COUNT-1:0] eligible;
    logic [MASTER_COUNT-1:0] resume_set;
    logic [MASTER_COUNT-1:0] res_oh;
    logic [MASTER_COUNT-1:0] ptr_mask;
    logic [MASTER_COUNT-1:0] rr_pool;
    logic [MASTER_COUNT-1:0] rr_oh;
    logic [2:0]              rr_idx;
    logic [2:0]              ptr_d;
    logic [SIDX_WIDTH-1:0]   split_idx;
    logic [SLAVE_COUNT-1:0]  split_sel;
    logic                    split_done_now;
    logic [MASTER_COUNT-1:0] done_hit;
    logic [MASTER_COUNT-1:0] park_keep;
    logic [MASTER_COUNT-1:0] resume_keep;
    logic                    owner_req;

    always_comb begin
        // NOTE: every signal gets a default before any conditional write so
        // no path leaves a value unassigned and no latch is inferred.
        done_hit  = '0;
        split_idx = '0;
        ptr_mask  = '0;

        eligible = mbreq & ~park_q;
        // A parked master that has already dropped mbreq is being cancelled
        // this edge, so it must not be picked for a resume grant.
        resume_set = park_q & resume_q & mbreq;
        res_oh     = resume_set & (~resume_set + MASTER_COUNT'(1));

        // Search from the pointer upwards first, then wrap to the bottom.
        for (int j = 0; j < MASTER_COUNT; j++) begin
            ptr_mask[j] = (3'(j) >= ptr_q);
        end
        rr_pool = (|(eligible & ptr_mask)) ? (eligible & ptr_mask) : eligible;
        rr_oh   = rr_pool & (~rr_pool + MASTER_COUNT'(1));
        rr_idx  = oh_to_idx(rr_oh);
        ptr_d   = (rr_idx == 3'(MASTER_COUNT - 1)) ? 3'd0 : rr_idx + 3'd1;

        // Lowest set bit of split_slave wins; an all-zero vector maps to 0.
        for (int s = SLAVE_COUNT - 1; s >= 0; s--) begin
            if (split_slave[s]) split_idx = SIDX_WIDTH'(s);
        end
        split_sel = (split_slave == '0) ? SLAVE_COUNT'(1)
                                        : (split_slave & (~split_slave + SLAVE_COUNT'(1)));
        // split_done for the slave that is splitting right now must not be lost.
        split_done_now = |(split_done & split_sel);

        for (int p = 0; p < MASTER_COUNT; p++) begin
            for (int s = 0; s < SLAVE_COUNT; s++) begin
                if (park_q[p] && slot_q[p] == SIDX_WIDTH'(s) && split_done[s]) begin
                    done_hit[p] = 1'b1;
                end
            end
        end

        // Park bookkeeping that applies every cycle: a parked master that
        // drops its request is cancelled, otherwise resume flags accumulate.
        park_keep   = park_q & mbreq;
        resume_keep = (resume_q | done_hit) & park_q & mbreq;

        owner_req = |(mbreq & grant_q);
    end

    // ------------------------------------------------------------------
    // Arbiter FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            park_q   <= '0;
            resume_q <= '0;
            ptr_q    <= '0;
            // NOTE: the park slots are few and are reset with everything else
            // so no stale slave index survives a reset.
            for (int p = 0; p < MASTER_COUNT; p++) begin
                slot_q[p] <= '0;
            end
        end else begin
            // NOTE: state is updated with non-blocking assignments only; later
            // assignments in this block override these defaults on the same edge.
            park_q   <= park_keep;
            resume_q <= resume_keep;

            case (state_q)
                ST_IDLE: begin
                    if (|resume_set) begin
                        // Resumed masters go ahead of normal arbitration and
                        // leave the round-robin pointer untouched.
                        grant_q  <= res_oh;
                        park_q   <= park_keep & ~res_oh;
                        resume_q <= resume_keep & ~res_oh;
                        state_q  <= ST_BUSY;
                    end else if (|eligible) begin
                        grant_q <= rr_oh;
                        ptr_q   <= ptr_d;
                        state_q <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    if (split_req) begin
                        // Split has priority over a simultaneous request drop.
                        grant_q  <= '0;
                        park_q   <= park_keep | grant_q;
                        resume_q <= resume_keep | (split_done_now ? grant_q : '0);
                        for (int p = 0; p < MASTER_COUNT; p++) begin
                            if (grant_q[p]) slot_q[p] <= split_idx;
                        end
                        state_q <= ST_RELEASE;
                    end else if (!owner_req) begin
                        grant_q <= '0;
                        state_q <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mbgrant  = grant_q;
    assign msplit   = park_q;
    assign bus_busy = |grant_q;
    assign owner_id = oh_to_idx(grant_q);

endmodule

// File: tb/tb_bus_arbiter_split.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_split
//
// Directed bench for bus_arbiter_split (2 masters, 3 slaves). Each step sets
// the inputs, queues the outputs expected after the next rising edge, then
// pops and compares them one time unit after that edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_split;

    logic       clk;
    logic       rstn;
    logic [1:0] mbreq;
    logic [1:0] mbgrant;
    logic [1:0] msplit;
    logic       split_req;
    logic [2:0] split_slave;
    logic [2:0] split_done;
    logic       bus_busy;
    logic [2:0] owner_id;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string      tag;
        logic [1:0] grant;
        logic [1:0] split;
    } exp_t;

    exp_t sb_q[$];

    bus_arbiter_split #(
        .MASTER_COUNT (2),
        .SLAVE_COUNT  (3),
        .SIDX_WIDTH   (2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mbreq       (mbreq),
        .mbgrant     (mbgrant),
        .msplit      (msplit),
        .split_req   (split_req),
        .split_slave (split_slave),
        .split_done  (split_done),
        .bus_busy    (bus_busy),
        .owner_id    (owner_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare all outputs against a grant/split expectation.
    task automatic check_outputs(input string tag, input logic [1:0] eg, input logic [1:0] es);
        check({tag, "/mbgrant"},  {6'b0, mbgrant},  {6'b0, eg});
        check({tag, "/msplit"},   {6'b0, msplit},   {6'b0, es});
        check({tag, "/bus_busy"}, {7'b0, bus_busy}, {7'b0, |eg});
        check({tag, "/owner_id"}, {5'b0, owner_id}, eg[1] ? 8'd1 : 8'd0);
    endtask

    // One clock step: queue the expectation, let the edge happen, compare.
    task automatic tick(input string tag, input logic [1:0] eg, input logic [1:0] es);
        exp_t e;
        e.tag   = tag;
        e.grant = eg;
        e.split = es;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_outputs(e.tag, e.grant, e.split);
    endtask

    initial begin
        logic [1:0] rr_exp;

        rstn        = 1'b0;
        mbreq       = 2'b00;
        split_req   = 1'b0;
        split_slave = 3'b000;
        split_done  = 3'b000;

        #3;
        check_outputs("reset", 2'b00, 2'b00);
        @(negedge clk);
        rstn = 1'b1;

        // Single request: grant one edge after request, release then idle.
        mbreq = 2'b01;
        tick("single_grant", 2'b01, 2'b00);
        tick("single_hold1", 2'b01, 2'b00);
        tick("single_hold2", 2'b01, 2'b00);
        tick("single_hold3", 2'b01, 2'b00);
        mbreq = 2'b00;
        tick("single_release", 2'b00, 2'b00);
        tick("single_idle", 2'b00, 2'b00);

        // Round-robin: pointer is 1 after master0's grant, so master1 leads.
        mbreq = 2'b11;
        for (int g = 0; g < 4; g++) begin
            rr_exp = (g % 2 == 0) ? 2'b10 : 2'b01;
            tick($sformatf("rr%0d_grant", g), rr_exp, 2'b00);
            tick($sformatf("rr%0d_hold1", g), rr_exp, 2'b00);
            tick($sformatf("rr%0d_hold2", g), rr_exp, 2'b00);
            mbreq = 2'b11 & ~rr_exp;
            tick($sformatf("rr%0d_release", g), 2'b00, 2'b00);
            mbreq = 2'b11;
            tick($sformatf("rr%0d_idle", g), 2'b00, 2'b00);
        end
        mbreq = 2'b00;
        tick("rr_quiet", 2'b00, 2'b00);

        // Split and resume.
        mbreq = 2'b01;
        tick("split_own0", 2'b01, 2'b00);
        mbreq       = 2'b11;
        split_req   = 1'b1;
        split_slave = 3'b010;
        tick("split_park0", 2'b00, 2'b01);
        split_req   = 1'b0;
        split_slave = 3'b000;
        tick("split_idle", 2'b00, 2'b01);
        tick("split_grant1", 2'b10, 2'b01);
        tick("split_hold1", 2'b10, 2'b01);
        mbreq      = 2'b01;
        split_done = 3'b010;
        tick("resume_release1", 2'b00, 2'b01);
        split_done = 3'b000;
        mbreq      = 2'b11;
        tick("resume_idle", 2'b00, 2'b01);
        tick("resume_grant0", 2'b01, 2'b00);
        tick("resume_hold0", 2'b01, 2'b00);

        // Split coinciding with the owner dropping its request: split wins.
        mbreq       = 2'b10;
        split_req   = 1'b1;
        split_slave = 3'b100;
        tick("splitdrop_park", 2'b00, 2'b01);
        split_req   = 1'b0;
        split_slave = 3'b000;
        mbreq       = 2'b11;
        tick("splitdrop_idle", 2'b00, 2'b01);
        tick("splitdrop_grant1", 2'b10, 2'b01);

        // Parked master cancels; a later split_done gives it nothing.
        mbreq = 2'b10;
        tick("cancel_clear", 2'b10, 2'b00);
        split_done = 3'b100;
        tick("cancel_done_ignored", 2'b10, 2'b00);
        split_done = 3'b000;
        mbreq      = 2'b00;
        tick("cancel_release", 2'b00, 2'b00);
        tick("cancel_idle", 2'b00, 2'b00);
        tick("cancel_no_grant", 2'b00, 2'b00);

        // Async reset while busy with a master parked.
        mbreq = 2'b01;
        tick("rst_own0", 2'b01, 2'b00);
        split_req   = 1'b1;
        split_slave = 3'b001;
        tick("rst_park0", 2'b00, 2'b01);
        split_req   = 1'b0;
        split_slave = 3'b000;
        mbreq       = 2'b11;
        tick("rst_idle", 2'b00, 2'b01);
        tick("rst_grant1", 2'b10, 2'b01);
        #2;
        rstn = 1'b0;
        #1;
        check_outputs("rst_async", 2'b00, 2'b00);
        mbreq = 2'b10;
        @(negedge clk);
        rstn = 1'b1;
        tick("rst_after_grant1", 2'b10, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
